// File: rtl/bf16_pkg.sv
// Shared bf16 types and constants for the shared-adder arbiter and its response path.
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_ONE  = 16'h3F80;
  localparam bf16_t BF16_PINF = 16'h7F80;

  // Requester id width for the default four-requester configuration
  localparam int RSP_ID_W = 2;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    bf16_t               data;
  } bf16_rsp_t;

  // Modular add of a small offset to an index in 0..n-1
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/bf16_rsp_fifo.sv
// In-order response FIFO with a registered head entry.
// The head register is what the consumer sees, so data/id stay stable
// while the head waits. Push and pop may coincide at any fill level.
module bf16_rsp_fifo
  import bf16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_vld_q, head_vld_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_s, push_s, mem_we_s, full_s;
  logic [CNT_W-1:0] mem_cnt_s;

  // Compute head refill, storage write and occupancy for the next cycle
  always_comb begin
    full_s     = (count_q == CNT_W'(DEPTH));
    pop_s      = pop & head_vld_q;
    push_s     = push & (~full_s | pop_s);
    mem_cnt_s  = count_q - {{(CNT_W-1){1'b0}}, head_vld_q};
    head_vld_d = head_vld_q;
    head_d     = head_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_we_s   = 1'b0;
    if (~head_vld_q | pop_s) begin
      if (mem_cnt_s != {CNT_W{1'b0}}) begin
        head_d     = mem_q[rd_ptr_q];
        head_vld_d = 1'b1;
        rd_ptr_d   = PTR_W'(wrap_add(int'(rd_ptr_q), 1, DEPTH));
        mem_we_s   = push_s;
      end else if (push_s) begin
        head_d     = din;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else begin
      mem_we_s = push_s;
    end
    if (mem_we_s) begin
      wr_ptr_d = PTR_W'(wrap_add(int'(wr_ptr_q), 1, DEPTH));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control and head registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      head_vld_q <= 1'b0;
      head_q     <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  // Storage behind the head; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = head_q;
  assign full  = full_s;
  assign empty = ~head_vld_q;
  assign count = count_q;

endmodule

// File: rtl/bf16_addsub_arbiter.sv
// Round-robin sharing of one registered bf16 add/sub unit among NUM_REQ requesters.
// Issued ops are tracked by an id tag pipe matching the adder latency; results
// land in an in-order FIFO. The outstanding count caps issues at FIFO_DEPTH so
// the non-stallable adder can always push its result.
module bf16_addsub_arbiter
  import bf16_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_a,
  input  logic [NUM_REQ*16-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [15:0]             add_a,
  output logic [15:0]             add_b,
  output logic                    add_cntl,
  input  logic [15:0]             add_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]              outstanding_q, outstanding_d;
  logic                          busy_q, busy_d;
  logic [ADD_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [ADD_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

  logic                          grant_vld_s;
  logic [ID_W-1:0]               grant_id_s;
  logic                          issue_s;
  logic                          pop_s;
  logic                          fifo_empty_s, fifo_full_s;
  logic [CNT_W-1:0]              fifo_count_s;
  logic [ID_W+15:0]              fifo_dout_s;
  logic                          fifo_unused_s;

  // Requester index k positions after the round-robin pointer
  function automatic logic [ID_W-1:0] rr_cand(input logic [ID_W-1:0] ptr, input int k);
    return ID_W'(wrap_add(int'(ptr), k, NUM_REQ));
  endfunction

  // Pick the first valid requester starting at the round-robin pointer
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld_s && req_valid[rr_cand(rr_ptr_q, k)]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = rr_cand(rr_ptr_q, k);
      end else begin
        grant_vld_s = grant_vld_s;
        grant_id_s  = grant_id_s;
      end
    end
  end

  // Issue only with room for the result; a same-cycle pop does not make room
  assign issue_s = grant_vld_s & (outstanding_q < CNT_W'(FIFO_DEPTH)) & ~rst;
  assign pop_s   = rsp_valid & rsp_ready;

  // Grant and adder operands; all zero in cycles without an issue
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_cntl  = 1'b0;
    if (issue_s) begin
      req_ready[grant_id_s] = 1'b1;
      add_a                 = req_a[16*grant_id_s +: 16];
      add_b                 = req_b[16*grant_id_s +: 16];
      add_cntl              = req_sub[grant_id_s];
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next pointer, outstanding count, busy flag and tag pipe contents
  always_comb begin
    if (issue_s) begin
      rr_ptr_d = ID_W'(wrap_add(int'(grant_id_s), 1, NUM_REQ));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case ({issue_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1'b1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase
    busy_d       = (outstanding_d != {CNT_W{1'b0}});
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue_s;
    tag_id_d[0]  = grant_id_s;
    for (int i = 1; i < ADD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // State registers; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= {ID_W{1'b0}};
      outstanding_q <= {CNT_W{1'b0}};
      busy_q        <= 1'b0;
      tag_vld_q     <= {ADD_LAT{1'b0}};
      tag_id_q      <= {(ADD_LAT*ID_W){1'b0}};
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
    end
  end

  bf16_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W + 16)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_vld_q[ADD_LAT-1]),
    .din   ({tag_id_q[ADD_LAT-1], add_c}),
    .pop   (rsp_ready),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // The outstanding counter already bounds occupancy, so full/count are not needed here
  assign fifo_unused_s = ^{fifo_full_s, fifo_count_s};

  assign rsp_valid = ~fifo_empty_s;
  assign rsp_data  = fifo_dout_s[15:0];
  assign rsp_id    = fifo_dout_s[ID_W+15:16];
  assign busy      = busy_q;

endmodule

// File: tb/tb_bf16_addsub_arbiter.sv
// Bench for bf16_addsub_arbiter: a registered behavioural adder stands in for the
// shared unit; a queue-based model predicts grants, operands and responses.
module tb_bf16_addsub_arbiter;
  import bf16_pkg::*;

  localparam int NREQ = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_sub;
  logic [63:0] req_a, req_b;
  logic [15:0] add_a, add_b, add_c;
  logic        add_cntl;
  logic        rsp_valid, rsp_ready, busy;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_m = 0;

  typedef struct {
    bf16_rsp_t rsp;
    int        avail;
  } pend_t;
  pend_t q[$];

  logic [3:0]  obs_ready;
  logic        obs_valid, obs_busy;
  logic [15:0] obs_data;
  logic [1:0]  obs_id;

  always #5 clk = ~clk;

  bf16_addsub_arbiter #(.NUM_REQ(4), .ADD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_cntl(add_cntl), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  function automatic real bf2real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'h00) d = {x[15], 63'd0};
    else if (x[14:7] == 8'hFF) d = {x[15], 11'h7FF, x[6:0], 45'd0};
    else d = {x[15], ({3'b000, x[14:7]} + 11'd896), x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] real2bf(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return (d[51:0] != 52'd0) ? {d[63], 8'hFF, 7'h40} : {d[63], 8'hFF, 7'h00};
    if (e <= 896) return {d[63], 15'd0};
    if (e >= 896 + 255) return {d[63], 8'hFF, 7'h00};
    return {d[63], 8'(e - 896), d[51:45]};
  endfunction

  // Reference adder (truncating); NaN operands are returned unchanged
  function automatic logic [15:0] adder_ref(input logic [15:0] a, input logic [15:0] b, input logic sub);
    real rb;
    if (a[14:7] == 8'hFF && a[6:0] != 7'd0) return a;
    if (b[14:7] == 8'hFF && b[6:0] != 7'd0) return b;
    rb = sub ? -bf2real(b) : bf2real(b);
    return real2bf(bf2real(a) + rb);
  endfunction

  // Stand-in for the shared adder: one register stage
  always @(posedge clk) add_c <= adder_ref(add_a, add_b, add_cntl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    req_a   = {$urandom, $urandom};
    req_b   = {$urandom, $urandom};
    req_sub = 4'($urandom);
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic tick();
    bit found, issue, exp_valid;
    int g;
    logic [3:0] exp_ready;
    logic [15:0] ea, eb;
    logic es;
    pend_t p;
    @(negedge clk);
    #1;
    found = 0;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(rr_m + k) % NREQ]) begin
        found = 1;
        g = (rr_m + k) % NREQ;
      end
    end
    issue = !rst && found && (q.size() < DEPTH);
    exp_ready = issue ? 4'(1 << g) : 4'b0000;
    ea = issue ? req_a[16*g +: 16] : 16'h0000;
    eb = issue ? req_b[16*g +: 16] : 16'h0000;
    es = issue ? req_sub[g] : 1'b0;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_busy  = busy;
    obs_data  = rsp_data;
    obs_id    = rsp_id;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("add_a", 32'(add_a), 32'(ea));
    chk("add_b", 32'(add_b), 32'(eb));
    chk("add_cntl", 32'(add_cntl), 32'(es));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (exp_valid) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].rsp.data));
      chk("rsp_id", 32'(rsp_id), 32'(q[0].rsp.id));
    end
    if (rst) begin
      q.delete();
      rr_m = 0;
    end else begin
      if (exp_valid && rsp_ready) void'(q.pop_front());
      if (issue) begin
        p.rsp.id   = 2'(g);
        p.rsp.data = adder_ref(ea, eb, es);
        p.avail    = cyc + 2;
        q.push_back(p);
        rr_m = (g + 1) % NREQ;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  int accepts;
  int start;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, BF16_ONE, 16'h4000, 1'b0, 16'h4040};
    vecs[1] = '{2, 16'h4040, BF16_ONE, 1'b1, 16'h4000};
    vecs[2] = '{1, BF16_PINF, BF16_ONE, 1'b0, BF16_PINF};
    vecs[3] = '{3, 16'h7FC1, BF16_ONE, 1'b0, 16'h7FC1};
    vecs[4] = '{2, 16'h0000, BF16_ONE, 1'b1, 16'hBF80};
    vecs[5] = '{1, 16'h4100, 16'h4100, 1'b1, 16'h0000};

    // Reset, with requests present to show grants are held off
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    rand_ops();
    @(posedge clk);
    @(posedge clk);
    #1;
    tick();
    chk("reset rsp_data", 32'(rsp_data), 32'h0);
    chk("reset rsp_id", 32'(rsp_id), 32'h0);
    rst = 1'b0;
    req_valid = 4'h0;
    tick();

    // Single-op vectors from the table
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      req_valid = 4'(1 << vecs[i].id);
      req_a[16*vecs[i].id +: 16] = vecs[i].a;
      req_b[16*vecs[i].id +: 16] = vecs[i].b;
      req_sub[vecs[i].id] = vecs[i].sub;
      tick();
      chk("vec grant", 32'(obs_ready), 32'(1 << vecs[i].id));
      req_valid = 4'h0;
      tick();
      tick();
      chk("vec rsp_valid", 32'(obs_valid), 32'h1);
      chk("vec rsp_data", 32'(obs_data), 32'(vecs[i].exp));
      chk("vec rsp_id", 32'(obs_id), 32'(vecs[i].id));
      tick();
    end

    // All requesters streaming with a free consumer: one grant per cycle in rotation
    start = rr_m;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      tick();
      chk("rr stream grant", 32'(obs_ready), 32'(1 << ((start + k) % NREQ)));
    end
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) tick();

    // Stalled consumer: exactly DEPTH accepts, then back-pressure
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      tick();
      accepts += $countones(obs_ready);
    end
    chk("stall accepts", 32'(accepts), 32'd4);
    chk("stall ready", 32'(obs_ready), 32'h0);
    // Pop at full occupancy does not free a slot in the same cycle
    rsp_ready = 1'b1;
    tick();
    chk("full pop no issue", 32'(obs_ready), 32'h0);
    chk("full pop valid", 32'(obs_valid), 32'h1);
    tick();
    chk("issue after pop", 32'(obs_ready != 4'h0), 32'h1);
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      tick();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 6; k++) tick();

    // Reset with two operations in flight
    req_valid = 4'b0011;
    rand_ops();
    tick();
    tick();
    req_valid = 4'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst rsp_valid", 32'(obs_valid), 32'h0);
    chk("post-rst busy", 32'(obs_busy), 32'h0);
    for (int k = 0; k < 3; k++) tick();
    req_valid = 4'b1010;
    rand_ops();
    tick();
    chk("post-rst grant", 32'(obs_ready), 32'b0010);
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) tick();

    // Randomised traffic with back-pressure and occasional reset
    for (int k = 0; k < 600; k++) begin
      rand_ops();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
